// File: rtl/serial_frame_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_frame_pkg
// Brief    : Shared types and helpers for the serial frame controller:
//            FSM state encoding, port-id width and one-hot port decoding.
// Revision : 1.0  initial release
// ============================================================================
package serial_frame_pkg;

  localparam int PORT_ID_W = 2;
  localparam int MAX_PORTS = 1 << PORT_ID_W;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PORT = 3'd1,
    LEN  = 3'd2,
    DATA = 3'd3,
    PAR  = 3'd4,
    FIN  = 3'd5
  } frame_state_t;

  // One-hot decode of a port id; ids at or beyond the port count map to zero.
  function automatic logic [MAX_PORTS-1:0] onehot_port(input logic [PORT_ID_W-1:0] id,
                                                       input int ports);
    logic [MAX_PORTS-1:0] oh;
    oh = '0;
    if (int'(id) < ports) oh[id] = 1'b1;
    return oh;
  endfunction

endpackage
`default_nettype wire

// File: rtl/frame_field_shift.sv
`default_nettype none
// ============================================================================
// Module   : frame_field_shift
// Brief    : Shift-in / down-count register for frame header fields. Bits
//            enter MSB first at the LSB end; the same register can then be
//            decremented as a payload bit counter.
// Revision : 1.0  initial release
// ============================================================================
module frame_field_shift #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_shift,
  input  logic         i_dec,
  input  logic         i_bit,
  output logic [W-1:0] o_q,
  output logic [W-1:0] o_shifted
);

  logic [W-1:0] r_q;

  // Value the register takes if the current serial bit is shifted in now;
  // exposed so the FSM can test the completed field in the same cycle.
  generate
    if (W == 1) begin : g_single
      assign o_shifted = i_bit;
    end else begin : g_multi
      assign o_shifted = {r_q[W-2:0], i_bit};
    end
  endgenerate

  // Field register: clear has priority over shift, shift over decrement.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q <= '0;
    end else if (i_clr) begin
      r_q <= '0;
    end else if (i_shift) begin
      r_q <= o_shifted;
    end else if (i_dec) begin
      r_q <= r_q - W'(1);
    end
  end

  assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/serial_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_frame_ctrl
// Brief    : Parses serial frames (start, port id, length, payload, optional
//            parity) and steers payload bits to one of PORTS outputs with a
//            registered one-hot enable. Reports done/err per frame.
// Config   : FRAME_PARITY_EN - adds an even-parity bit after the payload.
// Revision : 1.0  initial release
// ============================================================================
module serial_frame_ctrl #(
  parameter int LEN_W = 4,
  parameter int PORTS = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ser_in,
  output logic             ser_out,
  output logic [PORTS-1:0] port_en,
  output logic             busy,
  output logic             done,
  output logic             err
);

  import serial_frame_pkg::*;

  localparam int FLD_MAX = (LEN_W > PORT_ID_W) ? LEN_W : PORT_ID_W;
  localparam int BC_W    = $clog2(FLD_MAX);
  localparam logic [BC_W-1:0] PORT_LAST = BC_W'(PORT_ID_W - 1);
  localparam logic [BC_W-1:0] LEN_LAST  = BC_W'(LEN_W - 1);

`ifdef FRAME_PARITY_EN
  localparam frame_state_t TAIL_ST = PAR;
`else
  localparam frame_state_t TAIL_ST = FIN;
`endif

  frame_state_t         r_state;
  frame_state_t         w_next;
  logic [BC_W-1:0]      r_bitcnt;
  logic                 w_bc_clr;
  logic                 w_bc_inc;
  logic                 w_fld_clr;
  logic                 w_pid_shift;
  logic                 w_len_shift;
  logic                 w_len_dec;
  logic [PORT_ID_W-1:0] w_port_id;
  logic [PORT_ID_W-1:0] w_pid_shifted_unused;
  logic [LEN_W-1:0]     w_len;
  logic [LEN_W-1:0]     w_len_shifted;
  logic [MAX_PORTS-1:0] w_onehot;
  logic                 w_onehot_unused;
  logic                 w_pid_invalid;

  frame_field_shift #(.W(PORT_ID_W)) u_port_id (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_fld_clr),
    .i_shift   (w_pid_shift),
    .i_dec     (1'b0),
    .i_bit     (ser_in),
    .o_q       (w_port_id),
    .o_shifted (w_pid_shifted_unused)
  );

  // Length field doubles as the remaining-payload counter during DATA.
  frame_field_shift #(.W(LEN_W)) u_length (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_fld_clr),
    .i_shift   (w_len_shift),
    .i_dec     (w_len_dec),
    .i_bit     (ser_in),
    .o_q       (w_len),
    .o_shifted (w_len_shifted)
  );

  assign w_onehot        = onehot_port(w_port_id, PORTS);
  assign w_onehot_unused = ^w_onehot;
  assign w_pid_invalid   = ~|w_onehot[PORTS-1:0];

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // Header bit position counter for the PORT and LEN fields.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          r_bitcnt <= '0;
    else if (w_bc_clr) r_bitcnt <= '0;
    else if (w_bc_inc) r_bitcnt <= r_bitcnt + BC_W'(1);
  end

  // Next-state and field strobes; FIN also watches for an immediate start bit.
  always_comb begin
    w_next      = r_state;
    w_fld_clr   = 1'b0;
    w_pid_shift = 1'b0;
    w_len_shift = 1'b0;
    w_len_dec   = 1'b0;
    w_bc_clr    = 1'b0;
    w_bc_inc    = 1'b0;
    case (r_state)
      IDLE, FIN: begin
        if (!ser_in) begin
          w_next    = PORT;
          w_fld_clr = 1'b1;
          w_bc_clr  = 1'b1;
        end else begin
          w_next = IDLE;
        end
      end
      PORT: begin
        w_pid_shift = 1'b1;
        if (r_bitcnt == PORT_LAST) begin
          w_bc_clr = 1'b1;
          w_next   = LEN;
        end else begin
          w_bc_inc = 1'b1;
        end
      end
      LEN: begin
        w_len_shift = 1'b1;
        if (r_bitcnt == LEN_LAST) begin
          w_bc_clr = 1'b1;
          w_next   = (w_len_shifted == '0) ? TAIL_ST : DATA;
        end else begin
          w_bc_inc = 1'b1;
        end
      end
      DATA: begin
        w_len_dec = 1'b1;
        if (w_len <= LEN_W'(1)) w_next = TAIL_ST;
      end
`ifdef FRAME_PARITY_EN
      PAR: begin
        w_next = FIN;
      end
`endif
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Payload steering: only DATA forwards the line; every other state blanks it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ser_out <= 1'b0;
      port_en <= '0;
    end else if (r_state == DATA) begin
      ser_out <= ser_in;
      port_en <= w_onehot[PORTS-1:0];
    end else begin
      ser_out <= 1'b0;
      port_en <= '0;
    end
  end

  assign busy = (r_state != IDLE);
  assign done = (r_state == FIN);

`ifdef FRAME_PARITY_EN
  logic r_par;

  // Running XOR of payload and parity bits; nonzero at FIN means odd ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                 r_par <= 1'b0;
    else if (w_fld_clr)                       r_par <= 1'b0;
    else if (r_state == DATA || r_state == PAR) r_par <= r_par ^ ser_in;
  end

  assign err = done & (w_pid_invalid | r_par);
`else
  assign err = done & w_pid_invalid;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_frame_ctrl
// Brief    : Self-checking bench for serial_frame_ctrl. Frames are described
//            at frame level; the expected per-cycle outputs are derived from
//            the frame layout and compared every clock.
// Config   : FRAME_PARITY_EN - must match the DUT build.
// Revision : 1.0  initial release
// ============================================================================
module tb_serial_frame_ctrl;

  localparam int LEN_W = 4;
  localparam int PORTS = 3;
`ifdef FRAME_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             ser_in = 1'b1;
  logic             ser_out;
  logic [PORTS-1:0] port_en;
  logic             busy;
  logic             done;
  logic             err;

  serial_frame_ctrl #(.LEN_W(LEN_W), .PORTS(PORTS)) dut (
    .clk     (clk),
    .rst     (rst),
    .ser_in  (ser_in),
    .ser_out (ser_out),
    .port_en (port_en),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Expected behaviour, one entry per clock edge of the stimulus stream.
  bit               q_bit[$];
  bit               q_ser[$];
  logic [PORTS-1:0] q_en[$];
  bit               q_busy[$];
  bit               q_done[$];
  bit               q_err[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_edge(input bit b, input bit s, input logic [PORTS-1:0] en,
                           input bit bz, input bit dn, input bit er);
    q_bit.push_back(b);
    q_ser.push_back(s);
    q_en.push_back(en);
    q_busy.push_back(bz);
    q_done.push_back(dn);
    q_err.push_back(er);
  endtask

  task automatic add_idle(input int n);
    for (int i = 0; i < n; i++) push_edge(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  // A frame occupies one edge per bit; payload edges show the bit one cycle
  // later, and the FIN cycle follows the frame's final edge.
  task automatic add_frame(input int pid, input int n, input logic [15:0] payload,
                           input bit parbit);
    logic [PORTS-1:0] en;
    bit bad;
    bit odd;
    bit b;
    bit is_pay;
    bit last;
    int ones;
    int total;
    en  = '0;
    bad = (pid >= PORTS);
    if (!bad) en[pid] = 1'b1;
    ones = 0;
    for (int j = 0; j < n; j++) ones += int'(payload[n-1-j]);
    odd   = PAR_EN && (((ones + int'(parbit)) % 2) == 1);
    total = 1 + 2 + LEN_W + n + (PAR_EN ? 1 : 0);
    for (int k = 0; k < total; k++) begin
      is_pay = 1'b0;
      if (k == 0)                b = 1'b0;
      else if (k <= 2)           b = bit'((pid >> (2 - k)) & 1);
      else if (k < 3 + LEN_W)    b = bit'((n >> (LEN_W - 1 - (k - 3))) & 1);
      else if (k < 3 + LEN_W + n) begin
        b      = payload[n-1-(k-3-LEN_W)];
        is_pay = 1'b1;
      end else                   b = parbit;
      last = (k == total - 1);
      push_edge(b, is_pay ? b : 1'b0, is_pay ? en : '0, 1'b1, last, last && (bad || odd));
    end
  endtask

  task automatic clear_model();
    q_bit.delete();
    q_ser.delete();
    q_en.delete();
    q_busy.delete();
    q_done.delete();
    q_err.delete();
  endtask

  // Drive the first 'count' stream bits and compare outputs after each edge.
  task automatic run_edges(input int count);
    for (int e = 0; e < count; e++) begin
      @(negedge clk);
      ser_in = q_bit[e];
      @(posedge clk);
      #1;
      check($sformatf("ser_out@%0d", e), ser_out, q_ser[e]);
      check($sformatf("port_en@%0d", e), port_en, q_en[e]);
      check($sformatf("busy@%0d", e), busy, q_busy[e]);
      check($sformatf("done@%0d", e), done, q_done[e]);
      if (q_done[e]) check($sformatf("err@%0d", e), err, q_err[e]);
    end
    clear_model();
  endtask

  initial begin
    int pid;
    int n;
    logic [15:0] payload;
    bit parbit;

    // Reset state
    rst    = 1'b0;
    ser_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ser_out", ser_out, 0);
    check("rst_port_en", port_en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    @(negedge clk);
    rst = 1'b1;

    // Directed frames: routing, invalid id, zero length, back-to-back
    add_idle(2);
    add_frame(1, 3, 16'b101, 1'b0);
    add_idle(1);
    add_frame(3, 2, 16'b11, 1'b0);
    add_idle(1);
    add_frame(0, 0, 16'h0, 1'b0);
    add_idle(2);
    add_frame(0, 3, 16'b110, 1'b0);
    add_frame(2, 4, 16'b1011, 1'b1);
    add_idle(2);
`ifdef FRAME_PARITY_EN
    add_frame(2, 2, 16'b11, 1'b0);
    add_idle(1);
    add_frame(2, 2, 16'b11, 1'b1);
    add_idle(1);
`endif
    // Randomized frames with random gaps (including none)
    for (int f = 0; f < 40; f++) begin
      pid     = int'($urandom_range(0, 3));
      n       = int'($urandom_range(0, 15));
      payload = 16'($urandom);
      parbit  = bit'($urandom_range(0, 1));
      add_frame(pid, n, payload, parbit);
      add_idle(int'($urandom_range(0, 2)));
    end
    add_idle(3);
    run_edges(q_bit.size());

    // Reset during the second of five payload bits
    add_idle(2);
    add_frame(1, 5, 16'b10110, 1'b0);
    run_edges(2 + 1 + 2 + LEN_W + 1);
    @(negedge clk);
    ser_in = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("async_ser_out", ser_out, 0);
    check("async_port_en", port_en, 0);
    check("async_busy", busy, 0);
    check("async_done", done, 0);
    check("async_err", err, 0);
    ser_in = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("in_rst_done@%0d", i), done, 0);
    end
    #6;
    rst = 1'b1;

    // A full frame after reset release must route normally
    add_idle(2);
    add_frame(2, 4, 16'b1101, 1'b1);
    add_idle(2);
    run_edges(q_bit.size());

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
